// File: rtl/rr_arbiter_onehot.sv
// ---------------------------------------------------------------------------
// rr_arbiter_onehot
//
// Round-robin arbiter with a registered one-hot grant and a valid/ready
// handshake. A rotating priority pointer moves to the slot just past each
// accepted winner, so every active requester is served in turn. Once a grant
// is registered it is held, unchanged, until downstream accepts it.
//
// Parameters
//   NUM_REQ      number of requesters (2..32)
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       synchronous active-low reset
//   req_i        request vector, bit i = requester i wants the resource
//   lock_i       (only with RR_ARB_LOCK_EN) keep the current owner on accept
//                while it still requests
//   gnt_ready_i  downstream accepts the current grant this cycle
//   gnt_o        registered one-hot grant, all-zero when not valid
//   gnt_valid_o  grant valid, held stable until accepted
//
// Build option
//   RR_ARB_LOCK_EN  when defined, adds lock_i and the ownership-lock feature.
//                   When undefined, every accept advances the pointer.
// ---------------------------------------------------------------------------
module rr_arbiter_onehot #(
    parameter int NUM_REQ = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
`ifdef RR_ARB_LOCK_EN
    input  logic               lock_i,
`endif
    input  logic               gnt_ready_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]         state_reg,  state_next;
    logic [PTR_W-1:0]   ptr_reg,    ptr_next;
    logic [PTR_W-1:0]   owner_reg,  owner_next;
    logic [NUM_REQ-1:0] gnt_reg,    gnt_next;
    logic               valid_reg,  valid_next;

    // -----------------------------------------------------------------------
    // Handshake and pointer advance
    // -----------------------------------------------------------------------
    logic             accept;
    logic             keep_owner;
    logic [PTR_W-1:0] adv_ptr;
    logic [PTR_W-1:0] arb_ptr;

    assign accept = (state_reg == ST_GRANT) && gnt_ready_i;

    // Explicit wrap so a non-power-of-two NUM_REQ never leaves the pointer
    // at an index with no requester behind it.
    assign adv_ptr = (owner_reg == LAST_IDX) ? '0 : owner_reg + PTR_W'(1);

`ifdef RR_ARB_LOCK_EN
    assign keep_owner = accept && lock_i && req_i[owner_reg];
`else
    assign keep_owner = 1'b0;
`endif

    // On an accept the new grant is chosen with the already-advanced pointer,
    // which is what gives back-to-back grants without a bubble.
    assign arb_ptr = accept ? adv_ptr : ptr_reg;

    // -----------------------------------------------------------------------
    // Winner selection: first set request at or above arb_ptr, otherwise the
    // first set request from index 0 (the wrap-around half of the scan).
    // -----------------------------------------------------------------------
    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] pick_req;
    logic               any_req;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign upper_mask[gi] = (PTR_W'(gi) >= arb_ptr);
        end
    endgenerate

    assign upper_req = req_i & upper_mask;
    assign any_req   = |req_i;
    assign pick_req  = (|upper_req) ? upper_req : req_i;

    // Lowest set bit of pick_req; scanning downward leaves the lowest index.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_req[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign win_onehot[gi] = any_req && (win_idx == PTR_W'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        gnt_next   = gnt_reg;
        valid_next = valid_reg;

        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_next   = win_onehot;
                    valid_next = 1'b1;
                    owner_next = win_idx;
                    state_next = ST_GRANT;
                end else begin
                    gnt_next   = '0;
                    valid_next = 1'b0;
                end
            end

            ST_GRANT: begin
                // Without an accept everything holds: a registered grant is
                // never revoked, even if its requester lets go.
                if (accept && !keep_owner) begin
                    ptr_next = adv_ptr;
                    if (any_req) begin
                        gnt_next   = win_onehot;
                        valid_next = 1'b1;
                        owner_next = win_idx;
                    end else begin
                        gnt_next   = '0;
                        valid_next = 1'b0;
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            gnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            gnt_reg   <= gnt_next;
            valid_reg <= valid_next;
        end
    end

    assign gnt_o       = gnt_reg;
    assign gnt_valid_o = valid_reg;

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_onehot
//
// Directed bench for rr_arbiter_onehot with NUM_REQ=8. Inputs change 1 ns
// after a rising edge; outputs are checked 1 ns after the edge that registers
// them. Each check compares {gnt_valid_o, gnt_o} against a hand-computed value.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_onehot;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       ready;
    logic       lock;
    logic [7:0] gnt;
    logic       gnt_valid;

    int checks = 0;
    int errors = 0;

    rr_arbiter_onehot #(
        .NUM_REQ(8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
`ifdef RR_ARB_LOCK_EN
        .lock_i      (lock),
`endif
        .gnt_ready_i (ready),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic exp_valid, input logic [7:0] exp_gnt);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {gnt_valid, gnt};
        exp = {exp_valid, exp_gnt};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed valid=%b gnt=%h expected valid=%b gnt=%h",
                   tag, obs[8], obs[7:0], exp[8], exp[7:0]);
        end
        $display("check %-14s req=%h ready=%b -> valid=%b gnt=%h", tag, req, ready, gnt_valid, gnt);
    endtask

    initial begin
        logic [7:0] full_seq [0:7];
        full_seq[0] = 8'h02; full_seq[1] = 8'h04; full_seq[2] = 8'h08; full_seq[3] = 8'h10;
        full_seq[4] = 8'h20; full_seq[5] = 8'h40; full_seq[6] = 8'h80; full_seq[7] = 8'h01;

        rst_n = 1'b0;
        req   = 8'hFF;
        ready = 1'b0;
        lock  = 1'b0;

        // Reset held two cycles with all requests present: nothing granted.
        step(); chk("reset_1", 1'b0, 8'h00);
        step(); chk("reset_2", 1'b0, 8'h00);
        rst_n = 1'b1;

        // First grant one cycle after release, pointer at 0.
        step(); chk("first_grant", 1'b1, 8'h01);

        // Full load with continuous accept: rotates through all and wraps.
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(); chk("full_load", 1'b1, full_seq[i]);
        end

        // Two requesters alternate.
        req = 8'h81;
        step(); chk("two_req_a", 1'b1, 8'h80);
        step(); chk("two_req_b", 1'b1, 8'h01);
        step(); chk("two_req_c", 1'b1, 8'h80);
        step(); chk("two_req_d", 1'b1, 8'h01);

        // Accept with no requests: back to idle, pointer now 1.
        req = 8'h00;
        step(); chk("drain", 1'b0, 8'h00);

        // Backpressure: grant 04 holds while new requests arrive.
        req = 8'h04; ready = 1'b0;
        step(); chk("bp_grant", 1'b1, 8'h04);
        req = 8'h06;
        step(); chk("bp_hold_1", 1'b1, 8'h04);
        step(); chk("bp_hold_2", 1'b1, 8'h04);
        step(); chk("bp_hold_3", 1'b1, 8'h04);
        ready = 1'b1;
        step(); chk("bp_wrap", 1'b1, 8'h02);
        req = 8'h00;
        step(); chk("bp_empty", 1'b0, 8'h00);
        // Ready while idle is ignored; pointer stays 2.
        step(); chk("idle_ready", 1'b0, 8'h00);

`ifdef RR_ARB_LOCK_EN
        // Lock keeps owner 0 across accepts; from pointer 2 the scan wraps to 0.
        req = 8'h03; lock = 1'b1; ready = 1'b0;
        step(); chk("lock_grant", 1'b1, 8'h01);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); chk("lock_hold", 1'b1, 8'h01);
        end
        lock = 1'b0;
        step(); chk("lock_release", 1'b1, 8'h02);
        req = 8'h00;
        step(); chk("lock_drain", 1'b0, 8'h00);
`endif

        // Mid-grant reset. Pointer is 2 here, so 08 wins from idle.
        req = 8'h08; ready = 1'b0;
        step(); chk("mid_grant", 1'b1, 8'h08);
        req = 8'h00;
        step(); chk("owner_drop", 1'b1, 8'h08);
        req = 8'h08; rst_n = 1'b0;
        step(); chk("mid_reset", 1'b0, 8'h00);
        // Pointer back at 0: with 0A the winner is bit 1, not bit 3.
        rst_n = 1'b1; req = 8'h0A;
        step(); chk("post_reset", 1'b1, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_onehot.md
# rr_arbiter_onehot

Round-robin arbiter that picks one of NUM_REQ requesters per cycle and presents the winner as a registered one-hot grant vector with a valid/ready handshake. It sits directly upstream of the one-hot-to-binary encoder. Downstream logic consumes gnt_o, converts it to an index for muxing a shared resource, and returns gnt_ready_i when the granted transaction is accepted. Fairness comes from a rotating priority pointer that advances past each accepted winner.

## Interface
- NUM_REQ, default 8: number of requesters; legal range 2..32.
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_ni  input  1  reset, synchronous, active-low; sampled on clk_i rising edge.
- req_i  input  NUM_REQ  request vector; bit i = requester i wants the resource.
- gnt_o  output  NUM_REQ  registered grant; one-hot when gnt_valid_o=1, all-zero otherwise.
- gnt_valid_o  output  1  grant is valid and held stable.
- gnt_ready_i  input  1  downstream accepts the current grant in this cycle.
- lock_i  input  1  present only with RR_ARB_LOCK_EN; keeps current owner on accept.

## Operation
- Internal state:
  - ptr: priority pointer, $clog2(NUM_REQ) bits.
  - owner: index of the current grant.
  - FSM with states IDLE and GRANT.
- Winner selection (combinational) is the first set bit of req_i, scanning from index ptr upward and wrapping from NUM_REQ-1 to 0.
- IDLE:
  - If |req_i, register the winner: gnt_o = 1<<winner, gnt_valid_o = 1, owner = winner, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- GRANT, gnt_ready_i=0:
  - gnt_o, gnt_valid_o and owner hold.
  - Changes on req_i are ignored, including the owner dropping its request. A grant is never revoked.
- GRANT, gnt_ready_i=1 (accept):
  - ptr <= (owner+1) mod NUM_REQ. When owner = NUM_REQ-1, ptr wraps to 0.
  - Re-arbitrate in the same cycle, using the updated pointer value on the current req_i.
  - If a winner exists, register the new grant and stay in GRANT.
  - If no winner exists, clear gnt_o and gnt_valid_o and go to IDLE.
- Non-power-of-two NUM_REQ: ptr never holds a value at or above NUM_REQ. The wrap is explicit, not a natural overflow.
- Invariants:
  - gnt_o is one-hot or zero.
  - gnt_o != 0 exactly when gnt_valid_o = 1.
  - gnt_o is asserted only at a bit position whose req_i bit was 1 in the cycle the grant was registered.
- Reset: when rst_ni=0 at an edge, gnt_o=0, gnt_valid_o=0, ptr=0, owner=0, FSM=IDLE.
  - Applies unconditionally, including mid-grant.
  - Requests present in the reset cycle are not arbitrated.

## Timing
- Latency from req_i asserted in IDLE to gnt_valid_o: 1 cycle (grant visible after the next edge).
- Throughput: one grant per cycle when gnt_ready_i is held high and requests are pending. There is no bubble between consecutive grants.
- gnt_o and gnt_valid_o are driven directly from flops; there is no combinational path from any input to any output.
- Handshake:
  - Transfer occurs on an edge where gnt_valid_o=1 and gnt_ready_i=1.
  - gnt_ready_i while gnt_valid_o=0 is ignored.
- Simultaneous accept and new requests: the new requests take part in the same-cycle re-arbitration.

## Configuration
- RR_ARB_LOCK_EN defined:
  - The lock_i port exists.
  - On accept with lock_i=1 and req_i[owner]=1, the same owner is re-granted: gnt_o is unchanged, gnt_valid_o stays 1, and ptr is not advanced.
  - On accept with lock_i=1 and req_i[owner]=0, behaviour is normal round-robin.
  - lock_i is ignored when there is no accept.
- RR_ARB_LOCK_EN undefined:
  - No lock_i port.
  - Every accept advances ptr; pure round-robin.

## Test plan
All scenarios use NUM_REQ=8.
- Reset: hold rst_ni=0 for 2 cycles with req_i=8'hFF -> gnt_o=0 and gnt_valid_o=0 throughout. After release, the first grant is 8'h01 one cycle later.
- Full load with wrap: req_i=8'hFF, gnt_ready_i=1 -> gnt_o sequence 01,02,04,08,10,20,40,80,01, one per cycle with no gaps.
- Two requesters: req_i=8'h81, gnt_ready_i=1 -> gnt_o alternates 01,80,01,80.
- Backpressure: req_i=8'h04, gnt_ready_i=0 for 3 cycles, then req_i=8'h06 -> gnt_o=04 stays stable. Raising gnt_ready_i for one cycle gives next gnt_o=02 (ptr=3 wraps to bit 1). With no further requests after that accept -> gnt_valid_o=0.
- Lock (RR_ARB_LOCK_EN): req_i=8'h03, lock_i=1, gnt_ready_i=1 -> gnt_o=01 for 4 accepts. lock_i=0 -> next grant 02.
- Mid-grant reset: grant 08 pending with ready=0, then rst_ni=0 for one cycle -> gnt_o=0 at the next edge and ptr=0. With req_i=8'h0A after release -> grant 02.
